// File: rtl/store_checker.sv
// rtl/store_checker.sv - store-bus checker grading a core's data-memory writes against one expected signature
//
// Watches the core's store port for one run at a time. A run is armed by
// start and ends in PASS on the first store whose address and data both
// equal the programmed signature, or in FAIL once TIMEOUT cycles pass
// without one. Stores are counted and the most recent non-matching store
// is captured so a self-test program can be graded on hardware.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous active-high clear of all state
//   start      in   one-cycle pulse, arms (or restarts) a run
//   expadr     in   expected store address, stable while busy
//   expdata    in   expected store data, stable while busy
//   memwrite   in   store strobe from the core
//   dataadr    in   store address from the core
//   writedata  in   store data from the core
//   busy       out  run in progress
//   done       out  run finished (sticky until start/reset)
//   pass       out  run finished with a match
//   storecount out  stores seen this run, saturating at 255
//   mismatches out  non-matching stores this run, saturating at 255
//   lastadr    out  address of the most recent non-matching store
//   lastdata   out  data of the most recent non-matching store
//   cycles     out  cycles elapsed in the run, frozen once done

module store_checker #(
  parameter int TIMEOUT = 985,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [31:0]   expadr,
  input  logic [31:0]   expdata,
  input  logic          memwrite,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    storecount,
  output logic [7:0]    mismatches,
  output logic [31:0]   lastadr,
  output logic [31:0]   lastdata,
  output logic [CW-1:0] cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_e;

  localparam logic [CW-1:0] LAST_CYCLE = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic [7:0]    storecount_q, storecount_d;
  logic [7:0]    mismatches_q, mismatches_d;
  logic [31:0]   lastadr_q, lastadr_d;
  logic [31:0]   lastdata_q, lastdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          hit;

  assign hit = memwrite && (dataadr == expadr) && (writedata == expdata);

  always_comb begin
    state_d      = state_q;
    cycles_d     = cycles_q;
    storecount_d = storecount_q;
    mismatches_d = mismatches_q;
    lastadr_d    = lastadr_q;
    lastdata_d   = lastdata_q;

    if (start) begin
      // Arming and restarting are identical from every state; a store
      // sampled together with start belongs to no run.
      state_d      = S_RUN;
      cycles_d     = '0;
      storecount_d = '0;
      mismatches_d = '0;
      lastadr_d    = '0;
      lastdata_d   = '0;
    end else if (state_q == S_RUN) begin
      cycles_d = cycles_q + CW'(1);
      if (memwrite) begin
        if (storecount_q != 8'hff) begin
          storecount_d = storecount_q + 8'd1;
        end
        if (!hit) begin
          if (mismatches_q != 8'hff) begin
            mismatches_d = mismatches_q + 8'd1;
          end
          lastadr_d  = dataadr;
          lastdata_d = writedata;
        end
      end
      // A match on the final cycle still wins over the timeout. On either
      // terminal transition the cycle count stays at its current value.
      if (hit) begin
        state_d  = S_PASS;
        cycles_d = cycles_q;
      end else if (cycles_q == LAST_CYCLE) begin
        state_d  = S_FAIL;
        cycles_d = cycles_q;
      end
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_PASS) || (state_d == S_FAIL);
    pass_d = (state_d == S_PASS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cycles_q     <= '0;
      storecount_q <= '0;
      mismatches_q <= '0;
      lastadr_q    <= '0;
      lastdata_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycles_q     <= cycles_d;
      storecount_q <= storecount_d;
      mismatches_q <= mismatches_d;
      lastadr_q    <= lastadr_d;
      lastdata_q   <= lastdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign storecount = storecount_q;
  assign mismatches = mismatches_q;
  assign lastadr    = lastadr_q;
  assign lastdata   = lastdata_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_store_checker.sv
// tb/tb_store_checker.sv - self-checking bench for store_checker (short and default timeout instances)

module tb_store_checker;

  logic        clk;
  logic        rst, st, mw;
  logic [31:0] ea, ed, adr, wd;

  logic        busy_v [2];
  logic        done_v [2];
  logic        pass_v [2];
  logic [7:0]  sc_v   [2];
  logic [7:0]  mm_v   [2];
  logic [31:0] la_v   [2];
  logic [31:0] ld_v   [2];
  logic [15:0] cy_v   [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: run phase, raw store counts, and the edge at which
  // the run was armed; cycles are derived from edge arithmetic.
  int          tmo     [2];
  int          m_mode  [2];   // 0 idle, 1 run, 2 pass, 3 fail
  int          m_cnt   [2];
  int          m_mis   [2];
  int          m_sedge [2];
  int          m_frz   [2];
  logic [31:0] m_la    [2];
  logic [31:0] m_ld    [2];
  int          e = 0;

  store_checker #(.TIMEOUT(20), .CW(16)) u_a (
    .clk(clk), .reset(rst), .start(st), .expadr(ea), .expdata(ed),
    .memwrite(mw), .dataadr(adr), .writedata(wd),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .storecount(sc_v[0]), .mismatches(mm_v[0]),
    .lastadr(la_v[0]), .lastdata(ld_v[0]), .cycles(cy_v[0])
  );

  store_checker #(.TIMEOUT(985), .CW(16)) u_b (
    .clk(clk), .reset(rst), .start(st), .expadr(ea), .expdata(ed),
    .memwrite(mw), .dataadr(adr), .writedata(wd),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .storecount(sc_v[1]), .mismatches(mm_v[1]),
    .lastadr(la_v[1]), .lastdata(ld_v[1]), .cycles(cy_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int k);
    int el;
    if (rst) begin
      m_mode[k] = 0; m_cnt[k] = 0; m_mis[k] = 0;
      m_la[k] = 0; m_ld[k] = 0; m_frz[k] = 0;
    end else if (st) begin
      m_mode[k] = 1; m_cnt[k] = 0; m_mis[k] = 0;
      m_la[k] = 0; m_ld[k] = 0; m_sedge[k] = e;
    end else if (m_mode[k] == 1) begin
      el = e - m_sedge[k] - 1;
      if (mw) begin
        m_cnt[k]++;
        if (adr == ea && wd == ed) begin
          m_mode[k] = 2;
          m_frz[k]  = el;
        end else begin
          m_mis[k]++;
          m_la[k] = adr;
          m_ld[k] = wd;
        end
      end
      if (m_mode[k] == 1 && el == tmo[k] - 1) begin
        m_mode[k] = 3;
        m_frz[k]  = el;
      end
    end
  endtask

  task automatic check_all();
    int exp_cyc;
    for (int k = 0; k < 2; k++) begin
      exp_cyc = (m_mode[k] == 1) ? (e - m_sedge[k]) : ((m_mode[k] == 0) ? 0 : m_frz[k]);
      check($sformatf("busy%0d", k), 32'(busy_v[k]), 32'(m_mode[k] == 1));
      check($sformatf("done%0d", k), 32'(done_v[k]), 32'(m_mode[k] >= 2));
      check($sformatf("pass%0d", k), 32'(pass_v[k]), 32'(m_mode[k] == 2));
      check($sformatf("storecount%0d", k), 32'(sc_v[k]), 32'((m_cnt[k] > 255) ? 255 : m_cnt[k]));
      check($sformatf("mismatches%0d", k), 32'(mm_v[k]), 32'((m_mis[k] > 255) ? 255 : m_mis[k]));
      check($sformatf("lastadr%0d", k), la_v[k], m_la[k]);
      check($sformatf("lastdata%0d", k), ld_v[k], m_ld[k]);
      check($sformatf("cycles%0d", k), 32'(cy_v[k]), 32'(exp_cyc));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    e++;
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_in();
    rst = 1'b0; st = 1'b0; mw = 1'b0; adr = '0; wd = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mw = 1'b1; adr = a; wd = d;
    tick();
    mw = 1'b0;
  endtask

  task automatic arm(input logic [31:0] a, input logic [31:0] d);
    ea = a; ed = d; st = 1'b1;
    tick();
    st = 1'b0;
  endtask

  initial begin
    int first;
    tmo[0] = 20;
    tmo[1] = 985;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_cnt[k] = 0; m_mis[k] = 0; m_sedge[k] = 0;
      m_frz[k] = 0; m_la[k] = 0; m_ld[k] = 0;
    end
    ea = '0; ed = '0;
    idle_in();
    rst = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy_v[0]), 0);
    check("rst_done", 32'(done_v[0]), 0);
    check("rst_lastadr", la_v[0], 0);

    // Pass then re-arm
    arm(32'd18, 32'd21);
    tick();
    store(32'h54, 32'd7);
    tick();
    store(32'd18, 32'd21);
    check("pt_pass", 32'(pass_v[0]), 1);
    check("pt_done", 32'(done_v[0]), 1);
    check("pt_storecount", 32'(sc_v[0]), 2);
    check("pt_mismatches", 32'(mm_v[0]), 1);
    check("pt_lastadr", la_v[0], 32'h54);
    check("pt_lastdata", ld_v[0], 32'd7);
    mw = 1'b1; adr = 32'd18; wd = 32'd21;
    for (int i = 0; i < 5; i++) tick();
    mw = 1'b0;
    check("frozen_storecount", 32'(sc_v[0]), 2);
    arm(32'h2c, 32'd9);
    store(32'h2c, 32'd9);
    check("rearm_pass", 32'(pass_v[0]), 1);
    check("rearm_storecount", 32'(sc_v[0]), 1);

    // Timeout
    arm(32'h0ffffffc, 32'h3f8);
    first = -1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (done_v[0] && first < 0) first = i;
    end
    check("to_edge", 32'(first), 20);
    check("to_pass", 32'(pass_v[0]), 0);
    check("to_cycles", 32'(cy_v[0]), 19);

    // Near-miss
    arm(32'h1263ff00, 32'd0);
    store(32'h1263ff00, 32'd1);
    store(32'h1263ff01, 32'd0);
    for (int i = 0; i < 30 && !done_v[0]; i++) tick();
    check("nm_done", 32'(done_v[0]), 1);
    check("nm_pass", 32'(pass_v[0]), 0);
    check("nm_mismatches", 32'(mm_v[0]), 2);
    check("nm_lastadr", la_v[0], 32'h1263ff01);
    check("nm_lastdata", ld_v[0], 32'd0);

    // Match on the last cycle before timeout
    arm(32'h100, 32'h200);
    for (int i = 0; i < 19; i++) tick();
    check("bd_cycles", 32'(cy_v[0]), 19);
    store(32'h100, 32'h200);
    check("bd_pass", 32'(pass_v[0]), 1);

    // Saturation on the long-timeout instance
    arm(32'h0, 32'h0);
    mw = 1'b1; adr = 32'h1; wd = 32'h5;
    for (int i = 0; i < 300; i++) tick();
    mw = 1'b0;
    check("sat_storecount", 32'(sc_v[1]), 255);
    check("sat_mismatches", 32'(mm_v[1]), 255);

    // Restart mid-run, reset over start, store in idle
    arm(32'h40, 32'h1);
    store(32'h44, 32'h1);
    store(32'h48, 32'h1);
    store(32'h4c, 32'h1);
    st = 1'b1; mw = 1'b1; adr = 32'h50; wd = 32'h2;
    tick();
    st = 1'b0; mw = 1'b0;
    check("rs_storecount", 32'(sc_v[0]), 0);
    check("rs_mismatches", 32'(mm_v[0]), 0);
    check("rs_busy", 32'(busy_v[0]), 1);
    check("rs_cycles", 32'(cy_v[0]), 0);
    tick();
    rst = 1'b1; st = 1'b1;
    tick();
    rst = 1'b0; st = 1'b0;
    check("rr_busy", 32'(busy_v[0]), 0);
    check("rr_done", 32'(done_v[0]), 0);
    check("rr_cycles", 32'(cy_v[0]), 0);
    store(32'h40, 32'h1);
    check("idle_storecount", 32'(sc_v[0]), 0);

    // Randomized phase; expected signature only changes with start
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(255) == 0);
      st  = ($urandom_range(47) == 0);
      if (st) begin
        ea = 32'($urandom_range(3));
        ed = 32'($urandom_range(1));
      end
      mw  = ($urandom_range(3) == 0);
      adr = ($urandom_range(7) == 0) ? $urandom : 32'($urandom_range(3));
      wd  = 32'($urandom_range(1));
      tick();
    end
    idle_in();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
